// File: rtl/mac_multi.sv
// mac_multi: multi-channel multiply-accumulate with frame tags.
// The channels share one coefficient stream and one set of tags.
// Each frame result is rounded, shifted and saturated to OWIDTH bits.

// mac_lane: one channel. It holds the product register, the accumulator
// and the saturated output register.
module mac_lane #(
  parameter int DWIDTH = 24,
  parameter int CWIDTH = 18,
  parameter int GUARD  = 4,
  parameter int OWIDTH = 24,
  parameter int OSHIFT = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DWIDTH-1:0] data,
  input  logic [CWIDTH-1:0] coef,
  input  logic              cap,      // accepted tap: capture the product
  input  logic              acc_en,   // stage-2 tap valid
  input  logic              acc_fst,  // stage-2 tap opens a frame
  input  logic              out_en,   // stage-2 tap closed a frame
  output logic [OWIDTH-1:0] out_data,
  output logic              out_ovf
);
  localparam int PW = DWIDTH + CWIDTH;
  localparam int AW = PW + GUARD;
  localparam int RW = AW + 1;  // one spare bit so the rounding add cannot wrap

  localparam logic signed [RW-1:0] ONE  = {{(RW-1){1'b0}}, 1'b1};
  localparam logic signed [RW-1:0] RND  = (ONE << OSHIFT) >> 1;  // 0 when OSHIFT == 0
  localparam logic signed [RW-1:0] OMAX = (ONE << (OWIDTH-1)) - ONE;
  localparam logic signed [RW-1:0] OMIN = ~OMAX;

  logic signed [PW-1:0] d_x, c_x, prod;
  logic signed [AW-1:0] prod_x, acc;
  logic signed [RW-1:0] rnd, shf;
  logic [OWIDTH-1:0]    sat_d;
  logic                 sat_o;

  // Sign-extend both operands to the full product width so the multiply
  // is exact in PW bits.
  assign d_x    = {{CWIDTH{data[DWIDTH-1]}}, data};
  assign c_x    = {{DWIDTH{coef[CWIDTH-1]}}, coef};
  assign prod_x = {{GUARD{prod[PW-1]}}, prod};

  // Stage 1: register the full-precision product.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  prod <= '0;
    else if (cap)  prod <= d_x * c_x;
  end

  // Stage 2: a first tag restarts the sum. Any other valid tap adds to it,
  // and overflow wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     acc <= '0;
    else if (acc_en)  acc <= acc_fst ? prod_x : acc + prod_x;
  end

  // Round half up, arithmetic shift, then clamp to the output range.
  always_comb begin
    rnd   = {acc[AW-1], acc} + RND;
    shf   = rnd >>> OSHIFT;
    sat_d = shf[OWIDTH-1:0];
    sat_o = 1'b0;
    if (shf > OMAX) begin
      sat_d = OMAX[OWIDTH-1:0];
      sat_o = 1'b1;
    end else if (shf < OMIN) begin
      sat_d = OMIN[OWIDTH-1:0];
      sat_o = 1'b1;
    end
  end

  // Stage 3: capture the frame result. It holds until the next frame ends.
  // The accumulator is sampled before a following first tag overwrites it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (out_en) begin
      out_data <= sat_d;
      out_ovf  <= sat_o;
    end
  end
endmodule

// mac_multi: shared tag pipeline plus NCH independent lanes.
module mac_multi #(
  parameter int NCH    = 2,
  parameter int DWIDTH = 24,
  parameter int CWIDTH = 18,
  parameter int GUARD  = 4,
  parameter int OWIDTH = 24,
  parameter int OSHIFT = 17
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [NCH*DWIDTH-1:0]   data_in,
  input  logic [CWIDTH-1:0]       coef_in,
  output logic                    out_valid,
  output logic [NCH*OWIDTH-1:0]   out_data,
  output logic [NCH-1:0]          out_ovf
);
  localparam int STAGES = 3;

  logic [NCH-1:0][DWIDTH-1:0] data_v;
  logic [NCH-1:0][OWIDTH-1:0] odat_v;
  logic [STAGES:0]            vld_pipe;  // frame-end tag travelling to the output
  logic                       tap_v1, tap_f1;

  assign data_v      = data_in;
  assign out_data    = odat_v;
  assign vld_pipe[0] = in_valid & in_last;
  assign out_valid   = vld_pipe[STAGES];

  // Tag pipeline. Tags count only on accepted taps. The last tag is shifted
  // through to become the output strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe[STAGES:1] <= '0;
      tap_v1             <= 1'b0;
      tap_f1             <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      tap_v1             <= in_valid;
      tap_f1             <= in_valid & in_first;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    mac_lane #(
      .DWIDTH(DWIDTH), .CWIDTH(CWIDTH), .GUARD(GUARD),
      .OWIDTH(OWIDTH), .OSHIFT(OSHIFT)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .data    (data_v[i]),
      .coef    (coef_in),
      .cap     (in_valid),
      .acc_en  (tap_v1),
      .acc_fst (tap_f1),
      .out_en  (vld_pipe[2]),
      .out_data(odat_v[i]),
      .out_ovf (out_ovf[i])
    );
  end
endmodule

// File: tb/tb_mac_multi.sv
// Testbench for mac_multi. It uses a behavioural frame model, a table of
// single-tap vectors and hand-written multi-tap sequences.
// Note: +131072 does not fit in an 18-bit signed coefficient. The exact
// gain -1.0 (-131072) is used instead, so the hand expectations are negated.
module tb_mac_multi;
  localparam int NCH = 2, DW = 24, CW = 18, G = 4, OW = 24, OS = 17;
  localparam int AW  = DW + CW + G;
  localparam int UNITY = -131072;

  logic clk, reset_n, in_valid, in_first, in_last, out_valid;
  logic [NCH*DW-1:0] data_in;
  logic [CW-1:0]     coef_in;
  logic [NCH*OW-1:0] out_data;
  logic [NCH-1:0]    out_ovf;

  mac_multi #(.NCH(NCH), .DWIDTH(DW), .CWIDTH(CW), .GUARD(G), .OWIDTH(OW), .OSHIFT(OS)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .data_in(data_in), .coef_in(coef_in),
    .out_valid(out_valid), .out_data(out_data), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic [NCH*OW-1:0] d; logic [NCH-1:0] o; } exp_t;
  typedef struct { int d0, d1, c, e0, e1; logic [NCH-1:0] ov; } vec_t;

  exp_t              q[$];
  longint            sum [NCH];
  logic [NCH*OW-1:0] hold_d;
  logic [NCH-1:0]    hold_o;
  int cyc, checks, errors, strobes;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Keep only the low AW bits, sign-extended: the accumulator wraps there.
  function automatic longint wrap(input longint v);
    return (v <<< (64 - AW)) >>> (64 - AW);
  endfunction

  // Frame model: a running sum per channel, then a rounded and clamped
  // result that becomes due three cycles after the last tap.
  task automatic model_tap(input bit f, input bit l, input int d0, input int d1,
                           input int c, input int due);
    int     d [NCH];
    longint r, mx;
    exp_t   e;
    d[0] = d0; d[1] = d1;
    mx = (64'sd1 <<< (OW - 1)) - 1;
    e.due = due; e.d = '0; e.o = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      sum[ch] = wrap((f ? 0 : sum[ch]) + longint'(d[ch]) * longint'(c));
      r = (sum[ch] + ((64'sd1 <<< OS) >>> 1)) >>> OS;
      if (r > mx)           begin r = mx;      e.o[ch] = 1'b1; end
      else if (r < -mx - 1) begin r = -mx - 1; e.o[ch] = 1'b1; end
      e.d[ch*OW +: OW] = r[OW-1:0];
    end
    if (l) q.push_back(e);
  endtask

  task automatic check_out();
    bit ev;
    ev = (q.size() > 0) && (q[0].due == cyc);
    if (ev) begin
      hold_d = q[0].d;
      hold_o = q[0].o;
      void'(q.pop_front());
    end
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_data",  64'(out_data),  64'(hold_d));
    chk("out_ovf",   64'(out_ovf),   64'(hold_o));
    if (out_valid) strobes++;
  endtask

  // Drive one cycle of input from a negedge. Then check the outputs at the
  // following negedge.
  task automatic step(input bit v, input bit f, input bit l,
                      input int d0, input int d1, input int c);
    in_valid = v; in_first = f; in_last = l;
    data_in  = {d1[DW-1:0], d0[DW-1:0]};
    coef_in  = c[CW-1:0];
    if (v) model_tap(f, l, d0, d1, c, cyc + 3);
    @(posedge clk); cyc++;
    @(negedge clk);
    check_out();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Assert reset between clock edges. The outputs must clear at once,
  // and any frame still in flight is dropped.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_ovf",   64'(out_ovf),   64'd0);
    q.delete();
    for (int ch = 0; ch < NCH; ch++) sum[ch] = 0;
    hold_d = '0; hold_o = '0;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    @(posedge clk); cyc++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [NCH*OW-1:0] pack2(input int e0, input int e1);
    return {e1[OW-1:0], e0[OW-1:0]};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    int   s0;
    vecs[0] = '{1000, -1000, UNITY, -1000, 1000, 2'b00};
    vecs[1] = '{1, -1, 65536, 1, 0, 2'b00};
    vecs[2] = '{3, -3, 65536, 2, -1, 2'b00};
    vecs[3] = '{-1, 1, 65536, 0, 1, 2'b00};
    vecs[4] = '{8388607, -8388608, UNITY, -8388607, 8388607, 2'b10};
    vecs[5] = '{0, 0, 131071, 0, 0, 2'b00};

    checks = 0; errors = 0; cyc = 0; strobes = 0;
    hold_d = '0; hold_o = '0;
    for (int ch = 0; ch < NCH; ch++) sum[ch] = 0;
    reset_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    data_in = '0; coef_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_data",  64'(out_data),  64'd0);
    chk("reset_ovf",   64'(out_ovf),   64'd0);
    reset_n = 1'b1;

    // Lone last after reset accumulates onto a zeroed accumulator.
    step(1, 0, 1, 5, 7, UNITY);
    idle(2);
    chk("orphan_last", 64'(out_data), 64'(pack2(-5, -7)));

    // Single-tap frames: unity gain, rounding edges, saturation edge.
    foreach (vecs[i]) begin
      step(1, 1, 1, vecs[i].d0, vecs[i].d1, vecs[i].c);
      idle(2);
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_data", i),  64'(out_data),  64'(pack2(vecs[i].e0, vecs[i].e1)));
      chk($sformatf("vec%0d_ovf", i),   64'(out_ovf),   64'(vecs[i].ov));
      idle(1);
    end

    // Four full-scale taps saturate both channels.
    for (int k = 0; k < 4; k++) step(1, k == 0, k == 3, 8388607, -8388608, 131071);
    idle(2);
    chk("sat_data", 64'(out_data), 64'(pack2(8388607, -8388608)));
    chk("sat_ovf",  64'(out_ovf),  64'd3);
    idle(2);

    // Back-to-back three-tap frames with no idle cycles, then the same
    // frames with bubbles inserted.
    for (int pass = 0; pass < 2; pass++) begin
      s0 = strobes;
      for (int k = 1; k <= 6; k++) begin
        step(1, (k % 3) == 1, (k % 3) == 0, k, -k, UNITY);
        if (pass == 1 && k != 3) idle(1);
      end
      idle(3);
      chk($sformatf("stream%0d_strobes", pass), 64'(strobes - s0), 64'd2);
      chk($sformatf("stream%0d_data", pass), 64'(out_data), 64'(pack2(-15, 15)));
    end

    // A first tag mid-frame restarts the frame. Only the final pair counts.
    s0 = strobes;
    step(1, 1, 0, 10, 3, UNITY);
    step(1, 0, 0, 10, 3, UNITY);
    step(1, 1, 0, 10, 3, UNITY);
    step(1, 0, 1, 10, 3, UNITY);
    idle(3);
    chk("restart_strobes", 64'(strobes - s0), 64'd1);
    chk("restart_data", 64'(out_data), 64'(pack2(-20, -6)));

    // Reset between the second and third taps: no output for that frame.
    s0 = strobes;
    step(1, 1, 0, 100, 200, UNITY);
    step(1, 0, 0, 100, 200, UNITY);
    do_reset();
    step(1, 0, 1, 100, 200, UNITY);
    idle(3);
    chk("rstmid_strobes", 64'(strobes - s0), 64'd1);
    chk("rstmid_data", 64'(out_data), 64'(pack2(-100, -200)));
    for (int k = 0; k < 3; k++) step(1, k == 0, k == 2, 100, 200, UNITY);
    idle(3);
    chk("after_rst_data", 64'(out_data), 64'(pack2(-300, -600)));

    // Random traffic against the model, with one reset partway through.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      step(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 4) == 0,
           int'($urandom) >>> 8, int'($urandom) >>> 8, int'($urandom) >>> 14);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_multi.md
Name: mac_multi

Overview:
Parametrised multi-channel multiply-accumulate engine for the FIR/decimator datapath.
- NCH sample channels (I/Q by default) share one coefficient stream.
- Each channel keeps a guard-bit accumulator; frames are delimited by first/last tags.
- At frame end each accumulator is rounded, shifted and saturated to OWIDTH.
- Pipelined and fully streaming: back-to-back frames with no bubbles; one tap per channel per clock.

Parameters:
NCH, 2, number of parallel channels
DWIDTH, 24, signed sample width per channel
CWIDTH, 18, signed coefficient width
GUARD, 4, accumulator guard bits (2^GUARD full-scale taps before wrap)
OWIDTH, 24, signed output width per channel
OSHIFT, 17, arithmetic right shift applied at output (after rounding)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  data_in/coef_in/tags valid this cycle
in_first  in  1  tap is first of frame (qualified by in_valid)
in_last  in  1  tap is last of frame (qualified by in_valid)
data_in  in  NCH*DWIDTH  packed signed samples, channel 0 in LSBs
coef_in  in  CWIDTH  signed coefficient shared by all channels
out_valid  out  1  one-cycle strobe, out_data/out_ovf updated
out_data  out  NCH*OWIDTH  packed signed results, channel 0 in LSBs
out_ovf  out  NCH  per-channel saturation flag for current result

Behaviour:
- Widths: product P = DWIDTH+CWIDTH bits, full precision. Accumulator A = P+GUARD bits, signed.
- Stage 1 (cycle N+1 after accepted tap at N): register each channel's product data*coef. Register valid/first/last tags alongside.
- Stage 2 (N+2):
  - valid & first: acc <= product (prior contents discarded).
  - valid & !first: acc <= acc + product.
  - Stage not valid: acc holds.
- Accumulator overflow wraps (two's complement). No detection; GUARD sizing is the caller's responsibility.
- Stage 3 (N+3), when the stage-2 tap carried last:
  - r = (acc + 2^(OSHIFT-1)) >>> OSHIFT (round half up; OSHIFT=0 means no rounding add).
  - If r > 2^(OWIDTH-1)-1: out = max positive, ovf=1.
  - If r < -2^(OWIDTH-1): out = min negative, ovf=1.
  - Else out = r, ovf=0.
  - out_valid=1 for exactly one cycle.
- Latency: in_valid&in_last at cycle N gives out_valid at N+3, fixed.
- out_data/out_ovf hold their value until the next out_valid.
- first & last on the same tap: single-product frame, output = rounded product.
- last with no preceding first since reset: accumulates onto the current acc (zero after reset).
- first arriving mid-frame (no last seen): silently restarts the frame; the partial sum is discarded and no output is produced.
- Back-to-back frames: a last at N followed by a first at N+1 must be handled. Stage 3 samples acc before the first overwrites it.
- in_valid low: bubble propagates; tags are ignored when in_valid=0.
- Reset (asynchronous, any time, including mid-frame): all pipeline regs, accumulators, out_valid, out_data, out_ovf clear to 0. No output for the interrupted frame. Accepts new taps on the first edge after release.
- Channels are fully independent arithmetically; all share tags and timing.

Test Plan:
1. Defaults; one tap first&last, ch0 data=1000, ch1 data=-1000, coef=131072 -> out_valid 3 cycles later; ch0=1000, ch1=-1000, ovf=0.
2. Rounding: single taps, coef=65536. Data=1 -> 1; data=-1 -> 0; data=3 -> 2 (1.5 rounds up).
3. Saturation: 4-tap frame, ch0 data=8388607, ch1 data=-8388608, coef=131071 -> ch0=8388607 and ch1=-8388608, out_ovf=2'b11.
4. Streaming: frames of 3 taps back-to-back, no idle; data=k, coef=131072 (k=1,2,3 then 4,5,6) -> outputs 6 then 15 on consecutive-frame strobes 3 cycles apart. in_valid gaps inserted mid-frame do not change the results.
5. Restart/orphan: first, tap, first, last, with data=10 and coef=131072 each tap -> single output 20. Separately, a lone last after reset with data=5 -> 5.
6. Reset mid-frame: assert reset_n=0 between the 2nd and 3rd tap -> outputs cleared immediately and no out_valid. The next full frame produces the correct sum.
